v_alu_issue_seq: RTL and testbench

//  Operand issue sequencer for the vector add/min/max ALU. Accepts one vector instruction at a time.

---
 rtl/v_alu_pkg.sv | 26 ++
 rtl/v_alu_issue_seq_if.sv | 54 +++++
 rtl/v_scalar_replicate.sv | 20 ++
 rtl/v_alu_issue_seq.sv | 145 ++++++++++++++
 tb/tb_v_alu_issue_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v_alu_pkg.sv
// Shared definitions for the vector ALU issue path: SEW codes, sequencer states,
// and register-geometry helpers.
package v_alu_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int words_of(int vlen, int dw);
    return vlen / dw;
  endfunction

  function automatic int widx_w_of(int vlen, int dw);
    return (vlen / dw > 1) ? $clog2(vlen / dw) : 1;
  endfunction

endpackage

// File: rtl/v_alu_issue_seq_if.sv
// Instruction, VRF-read and ALU-drive signals of the issue sequencer.
// master = sequencer side, slave = environment (decoder, VRF, ALU).
interface v_alu_issue_seq_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int VL_WIDTH    = 7,
  parameter int OPSEL_WIDTH = 9
);
  logic                   req_valid;
  logic                   req_ready;
  logic [4:0]             req_vs1;
  logic [4:0]             req_vs2;
  logic [4:0]             req_vd;
  logic [VL_WIDTH-1:0]    req_vl;
  logic [1:0]             req_sew;
  logic [OPSEL_WIDTH-1:0] req_opSel;
  logic                   req_use_scalar;
  logic [DATA_WIDTH-1:0]  req_scalar;

  logic                   vrf_rd_en;
  logic                   vrf_rd_gnt;
  logic [ADDR_WIDTH-1:0]  vrf_rd_addr0;
  logic [ADDR_WIDTH-1:0]  vrf_rd_addr1;
  logic [DATA_WIDTH-1:0]  vrf_rd_data0;
  logic [DATA_WIDTH-1:0]  vrf_rd_data1;

  logic [DATA_WIDTH-1:0]  alu_vec0;
  logic [DATA_WIDTH-1:0]  alu_vec1;
  logic                   alu_valid;
  logic [1:0]             alu_sew;
  logic [OPSEL_WIDTH-1:0] alu_opSel;
  logic                   alu_carry;
  logic [ADDR_WIDTH-1:0]  alu_addr;
  logic                   alu_resp_valid;

  logic                   busy;
  logic                   done;

  modport master (
    input  req_valid, req_vs1, req_vs2, req_vd, req_vl, req_sew, req_opSel,
           req_use_scalar, req_scalar, vrf_rd_gnt, vrf_rd_data0, vrf_rd_data1,
           alu_resp_valid,
    output req_ready, vrf_rd_en, vrf_rd_addr0, vrf_rd_addr1, alu_vec0, alu_vec1,
           alu_valid, alu_sew, alu_opSel, alu_carry, alu_addr, busy, done
  );

  modport slave (
    output req_valid, req_vs1, req_vs2, req_vd, req_vl, req_sew, req_opSel,
           req_use_scalar, req_scalar, vrf_rd_gnt, vrf_rd_data0, vrf_rd_data1,
           alu_resp_valid,
    input  req_ready, vrf_rd_en, vrf_rd_addr0, vrf_rd_addr1, alu_vec0, alu_vec1,
           alu_valid, alu_sew, alu_opSel, alu_carry, alu_addr, busy, done
  );
endinterface

// File: rtl/v_scalar_replicate.sv
// Broadcasts the low SEW bits of a scalar across a full ALU word (.vx operand).
module v_scalar_replicate
  import v_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] scalar,
  input  logic [1:0]            sew,
  output logic [DATA_WIDTH-1:0] vec
);
  always_comb begin
    vec = scalar;
    case (sew_e'(sew))
      SEW8:    vec = {(DATA_WIDTH/8){scalar[7:0]}};
      SEW16:   vec = {(DATA_WIDTH/16){scalar[15:0]}};
      SEW32:   vec = {(DATA_WIDTH/32){scalar[31:0]}};
      default: vec = scalar;
    endcase
  end
endmodule

// File: rtl/v_alu_issue_seq.sv
// Operand issue sequencer: streams vs1/vs2 words from the VRF into the ALU one per
// granted read, tracks in-flight results and pulses done when the last one returns.
module v_alu_issue_seq
  import v_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int VLEN        = 512,
  parameter int VL_WIDTH    = 7,
  parameter int OPSEL_WIDTH = 9,
  parameter int ALU_LATENCY = 6
) (
  input logic              clk,
  input logic              rst,
  v_alu_issue_seq_if.master bus
);
  localparam int WORDS    = words_of(VLEN, DATA_WIDTH);
  localparam int WIDX_W   = widx_w_of(VLEN, DATA_WIDTH);
  localparam int NW_W     = $clog2(WORDS + 1);
  localparam int OUT_W    = $clog2(ALU_LATENCY + 2) + 1;
  localparam int BYTE_SH  = $clog2(DATA_WIDTH / 8);
  localparam int BYTES_W  = VL_WIDTH + 4;

  state_e                 state_q, state_d;
  logic [4:0]             vs1_q, vs2_q, vd_q;
  logic [1:0]             sew_q;
  logic [OPSEL_WIDTH-1:0] opsel_q;
  logic                   use_scalar_q;
  logic [DATA_WIDTH-1:0]  scalar_q;
  logic [NW_W-1:0]        nwords_q;
  logic [WIDX_W-1:0]      widx_q;
  logic [OUT_W-1:0]       out_q;
  logic                   aluv_q;
  logic [ADDR_WIDTH-1:0]  alu_addr_q;
  logic                   done_q;

  logic [BYTES_W-1:0]     req_bytes, req_words_raw;
  logic [NW_W-1:0]        req_nwords;
  logic                   accept, rd_fire, last_gnt, drain_done;
  logic [DATA_WIDTH-1:0]  scalar_vec;

  // Tail word is issued whole; vl past VLMAX clamps to the full register.
  always_comb begin
    req_bytes     = (BYTES_W'(bus.req_vl) << bus.req_sew) + BYTES_W'(DATA_WIDTH/8 - 1);
    req_words_raw = req_bytes >> BYTE_SH;
    req_nwords    = (req_words_raw > BYTES_W'(WORDS)) ? NW_W'(WORDS) : NW_W'(req_words_raw);
  end

  assign accept     = bus.req_valid && (state_q == IDLE);
  assign rd_fire    = (state_q == RUN) && bus.vrf_rd_gnt;
  assign last_gnt   = rd_fire && (NW_W'(widx_q) == nwords_q - NW_W'(1));
  // The word issued this cycle is not yet counted, so it must hold off completion.
  assign drain_done = (state_q == DRAIN) && (out_q == '0) && !aluv_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = (req_nwords == '0) ? DRAIN : RUN;
      RUN:     if (last_gnt) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = 1'b0;
    bus.busy         = 1'b0;
    bus.vrf_rd_en    = 1'b0;
    bus.vrf_rd_addr0 = '0;
    bus.vrf_rd_addr1 = '0;
    case (state_q)
      IDLE:  bus.req_ready = 1'b1;
      RUN: begin
        bus.busy         = 1'b1;
        bus.vrf_rd_en    = 1'b1;
        bus.vrf_rd_addr0 = ADDR_WIDTH'({vs1_q, widx_q});
        bus.vrf_rd_addr1 = ADDR_WIDTH'({vs2_q, widx_q});
      end
      DRAIN: bus.busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      sew_q        <= '0;
      opsel_q      <= '0;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      nwords_q     <= '0;
      widx_q       <= '0;
      out_q        <= '0;
      aluv_q       <= 1'b0;
      alu_addr_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      if (accept) begin
        vs1_q        <= bus.req_vs1;
        vs2_q        <= bus.req_vs2;
        vd_q         <= bus.req_vd;
        sew_q        <= bus.req_sew;
        opsel_q      <= bus.req_opSel;
        use_scalar_q <= bus.req_use_scalar;
        scalar_q     <= bus.req_scalar;
        nwords_q     <= req_nwords;
        widx_q       <= '0;
      end else if (rd_fire) begin
        widx_q <= widx_q + 1'b1;
      end
      aluv_q     <= rd_fire;
      alu_addr_q <= rd_fire ? ADDR_WIDTH'({vd_q, widx_q}) : '0;
      done_q     <= drain_done;
      // Stray completions with nothing in flight must not wrap the counter.
      case ({aluv_q, bus.alu_resp_valid})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   if (out_q != '0) out_q <= out_q - 1'b1;
        default: ;
      endcase
    end
  end

  v_scalar_replicate #(.DATA_WIDTH(DATA_WIDTH)) u_rep (
    .scalar (scalar_q),
    .sew    (sew_q),
    .vec    (scalar_vec)
  );

  assign bus.alu_valid = aluv_q;
  assign bus.alu_vec0  = aluv_q ? (use_scalar_q ? scalar_vec : bus.vrf_rd_data0) : '0;
  assign bus.alu_vec1  = aluv_q ? bus.vrf_rd_data1 : '0;
  assign bus.alu_addr  = alu_addr_q;
  assign bus.alu_sew   = sew_q;
  assign bus.alu_opSel = opsel_q;
  assign bus.alu_carry = 1'b0;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_v_alu_issue_seq.sv
// Scoreboard bench for v_alu_issue_seq: VRF/ALU models drive the environment side,
// expected ALU words are queued at issue and checked by an independent monitor.
module tb_v_alu_issue_seq;
  localparam int DW = 64, AW = 32, VLW = 7, OSW = 9, LAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_alu_issue_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VL_WIDTH(VLW), .OPSEL_WIDTH(OSW)) bus ();

  v_alu_issue_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VLEN(512), .VL_WIDTH(VLW),
                    .OPSEL_WIDTH(OSW), .ALU_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  v0;
    logic [DW-1:0]  v1;
    logic [1:0]     sew;
    logic [OSW-1:0] op;
    bit             last;
  } exp_t;

  exp_t          exp_q[$];
  int            vcyc_q[$];
  logic [AW-1:0] rd0_q[$], rd1_q[$];
  logic [DW-1:0] vrf [32][8];
  int  n_tests = 0, n_fail = 0, cyc = 0;
  int  gnt_mode = 0, grants = 0, hold = 0;
  bit  done_pending = 0, done_seen = 0, alu_flush = 0, stray = 0;
  int  exp_done_cyc = 0, done_cyc = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rep(logic [DW-1:0] s, int sew);
    int w;
    logic [DW-1:0] r;
    w = 8 << sew;
    for (int i = 0; i < DW; i++) r[i] = s[i % w];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // VRF, grant pattern and fixed-latency ALU completion model.
  initial begin
    bit g, v;
    logic [AW-1:0] a0, a1;
    bit [5:0] resp_pipe;
    resp_pipe = '0;
    bus.vrf_rd_gnt = 1'b0;
    bus.vrf_rd_data0 = '0;
    bus.vrf_rd_data1 = '0;
    bus.alu_resp_valid = 1'b0;
    forever begin
      @(negedge clk);
      g  = bus.vrf_rd_en && bus.vrf_rd_gnt && !rst;
      a0 = bus.vrf_rd_addr0;
      a1 = bus.vrf_rd_addr1;
      v  = bus.alu_valid;
      if (g) begin
        grants++;
        rd0_q.push_back(a0);
        rd1_q.push_back(a1);
      end
      @(posedge clk);
      #1;
      bus.vrf_rd_data0 = g ? vrf[a0[7:3]][a0[2:0]] : {$urandom, $urandom};
      bus.vrf_rd_data1 = g ? vrf[a1[7:3]][a1[2:0]] : {$urandom, $urandom};
      case (gnt_mode)
        0: bus.vrf_rd_gnt = 1'b1;
        1: bus.vrf_rd_gnt = ($urandom_range(0, 3) != 0);
        default: begin
          if (grants == 3 && hold < 2) begin
            bus.vrf_rd_gnt = 1'b0;
            hold++;
          end else bus.vrf_rd_gnt = 1'b1;
        end
      endcase
      resp_pipe = {resp_pipe[4:0], v};
      if (alu_flush) resp_pipe = '0;
      bus.alu_resp_valid = resp_pipe[5] | stray;
    end
  end

  // Monitor: pops the scoreboard on every alu_valid and times done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.alu_valid) begin
          vcyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_alu_valid: got addr %0h expected no word (cycle %0d)", bus.alu_addr, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("alu_addr", bus.alu_addr, e.addr);
            chk("alu_vec0", bus.alu_vec0, e.v0);
            chk("alu_vec1", bus.alu_vec1, e.v1);
            chk("alu_sew", bus.alu_sew, e.sew);
            chk("alu_opSel", bus.alu_opSel, e.op);
            if (e.last) begin
              done_pending = 1;
              exp_done_cyc = cyc + LAT + 2;
            end
          end
        end else begin
          chk("idle_outputs_zero", bus.alu_vec0 | bus.alu_vec1 | DW'(bus.alu_addr), '0);
        end
        if (bus.done) begin
          if (!done_pending) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
          end else begin
            chk("done_cycle", cyc, exp_done_cyc);
            done_pending = 0;
            done_seen = 1;
            done_cyc = cyc;
          end
        end else if (done_pending && cyc > exp_done_cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_late: got no done expected at cycle %0d (cycle %0d)", exp_done_cyc, cyc);
          done_pending = 0;
          done_seen = 1;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic issue(input int vs1, vs2, vd, vl, sew, op, input bit use_s,
                       input logic [DW-1:0] sc, input int gm, output int t);
    int nw;
    exp_t e;
    logic [DW-1:0] s_rep;
    gnt_mode = gm;
    grants = 0;
    hold = 0;
    done_seen = 0;
    vcyc_q.delete();
    rd0_q.delete();
    rd1_q.delete();
    @(posedge clk);
    #1;
    bus.req_vs1 = 5'(vs1);
    bus.req_vs2 = 5'(vs2);
    bus.req_vd = 5'(vd);
    bus.req_vl = VLW'(vl);
    bus.req_sew = 2'(sew);
    bus.req_opSel = OSW'(op);
    bus.req_use_scalar = use_s;
    bus.req_scalar = sc;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1'b1);
    t = cyc;
    nw = ((vl << sew) + 7) / 8;
    if (nw > 8) nw = 8;
    s_rep = rep(sc, sew);
    for (int w = 0; w < nw; w++) begin
      e.addr = AW'(vd * 8 + w);
      e.v0 = use_s ? s_rep : vrf[vs1][w];
      e.v1 = vrf[vs2][w];
      e.sew = 2'(sew);
      e.op = OSW'(op);
      e.last = (w == nw - 1);
      exp_q.push_back(e);
    end
    if (nw == 0) begin
      done_pending = 1;
      exp_done_cyc = t + 2;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_vs1 = 5'($urandom);
    bus.req_vs2 = 5'($urandom);
    bus.req_vd = 5'($urandom);
    bus.req_vl = VLW'($urandom);
    bus.req_sew = 2'($urandom);
    bus.req_opSel = OSW'($urandom);
    bus.req_use_scalar = 1'($urandom);
    bus.req_scalar = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_seen) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    chk("all_words_issued", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit ok;
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < 8; w++) vrf[r][w] = {$urandom, $urandom};
    bus.req_valid = 1'b0;
    bus.req_vs1 = '0;
    bus.req_vs2 = '0;
    bus.req_vd = '0;
    bus.req_vl = '0;
    bus.req_sew = '0;
    bus.req_opSel = '0;
    bus.req_use_scalar = 1'b0;
    bus.req_scalar = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_alu_valid", bus.alu_valid, 1'b0);
    chk("rst_vrf_rd_en", bus.vrf_rd_en, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_alu_sew_op", {bus.alu_sew, bus.alu_opSel, bus.alu_carry}, '0);

    // vl=16 sew=32b, continuous grant
    issue(3, 7, 9, 16, 2, 'h1AB, 0, '0, 0, t);
    wait_done();
    chk("basic_word_count", vcyc_q.size(), 8);
    if (vcyc_q.size() > 0) chk("basic_first_valid", vcyc_q[0], t + 2);
    chk("basic_done_cycle", done_cyc, t + 17);
    chk("basic_rd_count", rd0_q.size(), 8);
    for (int k = 0; k < rd0_q.size() && k < 8; k++) begin
      chk("basic_rd_addr0", rd0_q[k], AW'(3 * 8 + k));
      chk("basic_rd_addr1", rd1_q[k], AW'(7 * 8 + k));
    end

    issue(1, 2, 4, 3, 0, 'h011, 0, '0, 0, t);
    wait_done();
    chk("vl3_word_count", vcyc_q.size(), 1);

    issue(5, 6, 30, 100, 0, 'h022, 0, '0, 0, t);
    wait_done();
    chk("clamp_word_count", vcyc_q.size(), 8);

    issue(8, 9, 10, 64, 0, 'h033, 1, 64'h0123_4567_89AB_CDA5, 0, t);
    wait_done();
    issue(11, 12, 13, 32, 1, 'h044, 1, 64'hFFFF_0000_5555_1234, 0, t);
    wait_done();

    // grant withheld for two cycles after word 2
    issue(14, 15, 16, 64, 0, 'h055, 0, '0, 2, t);
    wait_done();
    chk("gap_word_count", vcyc_q.size(), 8);
    if (vcyc_q.size() >= 4) begin
      chk("gap_w1_w2", vcyc_q[2] - vcyc_q[1], 1);
      chk("gap_w2_w3", vcyc_q[3] - vcyc_q[2], 3);
    end

    // vl=0: no words, done two cycles after accept
    issue(17, 18, 19, 0, 2, 'h066, 0, '0, 0, t);
    chk("vl0_ready_low", bus.req_ready, 1'b1 ^ bus.busy);
    @(negedge clk);
    wait_done();
    chk("vl0_no_words", vcyc_q.size(), 0);
    chk("vl0_done_cycle", done_cyc, t + 2);

    for (int n = 0; n < 20; n++) begin
      issue($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 127), $urandom_range(0, 3), $urandom_range(0, 511),
            1'($urandom), {$urandom, $urandom}, 1, t);
      wait_done();
    end

    // reset mid-instruction after word 3 has been issued
    issue(20, 21, 22, 64, 0, 'h077, 0, '0, 0, t);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (vcyc_q.size() >= 4) begin
        ok = 1;
        break;
      end
    end
    chk("mid_rst_reached_word3", ok, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    alu_flush = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    done_pending = 0;
    @(negedge clk);
    chk("mid_rst_alu_valid", bus.alu_valid, 1'b0);
    chk("mid_rst_rd_en", bus.vrf_rd_en, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_vecs", bus.alu_vec0 | bus.alu_vec1, '0);
    chk("mid_rst_addrs", {bus.alu_addr, bus.vrf_rd_addr0, bus.vrf_rd_addr1}, '0);
    chk("mid_rst_sew_op", {bus.alu_sew, bus.alu_opSel}, '0);
    chk("mid_rst_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    alu_flush = 0;
    stray = 1;
    repeat (3) @(posedge clk);
    #1;
    stray = 0;
    @(negedge clk);
    chk("stray_busy", bus.busy, 1'b0);

    issue(23, 24, 25, 24, 2, 'h088, 0, '0, 0, t);
    wait_done();
    chk("post_rst_word_count", vcyc_q.size(), 8);
    chk("post_rst_done_cycle", done_cyc, t + 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
